// File: rtl/egress_credit_buffer.sv
// Per-link egress buffer: per-VC FIFOs, per-VC downstream credits, round-robin launch to the endnode.
// Define ECB_STATS_EN to add the sent_cnt / stall_cnt statistics outputs.
//
// state  | meaning
// S_IDLE | output register empty; arbitrate over eligible VCs
// S_SEND | flit held on out_*; wait for out_accept
module egress_credit_buffer #(
  parameter int FLIT_W       = 32,
  parameter int NUM_VCS      = 2,
  parameter int DEPTH        = 8,
  parameter int INIT_CREDITS = 8,
  localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CW = $clog2(INIT_CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [VW-1:0]         in_vc,
  input  logic [FLIT_W-1:0]     in_flit,
  output logic [NUM_VCS-1:0]    in_ready,
  output logic                  out_valid,
  output logic [VW-1:0]         out_vc,
  output logic [FLIT_W-1:0]     out_flit,
  input  logic                  out_accept,
  input  logic [NUM_VCS-1:0]    credit_return,
  output logic [NUM_VCS*CW-1:0] credit_cnt,
  output logic                  credit_err
`ifdef ECB_STATS_EN
  ,
  output logic [NUM_VCS*16-1:0] sent_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t              r_state;
  logic [FLIT_W-1:0]   r_mem     [NUM_VCS][DEPTH];
  logic [AW-1:0]       r_wr_ptr  [NUM_VCS];
  logic [AW-1:0]       r_rd_ptr  [NUM_VCS];
  logic [AW:0]         r_count   [NUM_VCS];
  logic [CW-1:0]       r_credit  [NUM_VCS];
  logic [VW-1:0]       r_rr;
  logic [VW-1:0]       r_out_vc;
  logic [FLIT_W-1:0]   r_out_flit;
  logic                r_out_valid;
  logic                r_credit_err;

  logic [NUM_VCS-1:0]  w_ready, w_push, w_pop, w_elig, w_nonempty;
  logic                w_found;
  logic [VW-1:0]       w_pick, w_idx, w_rr_next;
  logic [VW:0]         w_sum;

  always_comb begin
    w_ready    = '0;
    w_push     = '0;
    w_elig     = '0;
    w_nonempty = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      w_nonempty[v] = (r_count[v] != '0);
      w_elig[v]     = w_nonempty[v] && (r_credit[v] != '0);
      w_ready[v]    = (r_count[v] != (AW+1)'(DEPTH));
      w_push[v]     = in_valid && (in_vc == VW'(v)) && w_ready[v];
    end
  end

  // Round-robin: first eligible VC at or after r_rr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      w_sum = {1'b0, r_rr} + (VW+1)'(i);
      if (w_sum >= (VW+1)'(NUM_VCS)) w_sum = w_sum - (VW+1)'(NUM_VCS);
      w_idx = w_sum[VW-1:0];
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
    w_rr_next = (w_pick == VW'(NUM_VCS - 1)) ? '0 : w_pick + VW'(1);
    w_pop = '0;
    if (r_state == S_IDLE && w_found) w_pop[w_pick] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (w_push[v]) begin
          r_mem[v][r_wr_ptr[v]] <= in_flit;
          r_wr_ptr[v]           <= r_wr_ptr[v] + AW'(1);
        end
        if (w_pop[v]) r_rd_ptr[v] <= r_rd_ptr[v] + AW'(1);
        if (w_push[v] && !w_pop[v])      r_count[v] <= r_count[v] + (AW+1)'(1);
        else if (!w_push[v] && w_pop[v]) r_count[v] <= r_count[v] - (AW+1)'(1);
      end
    end
  end

  // A return that lands on a full counter is a downstream bookkeeping error; the count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VCS; v++) r_credit[v] <= CW'(INIT_CREDITS);
      r_credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (w_pop[v] && !credit_return[v]) begin
          r_credit[v] <= r_credit[v] - CW'(1);
        end else if (credit_return[v] && !w_pop[v]) begin
          if (r_credit[v] == CW'(INIT_CREDITS)) r_credit_err <= 1'b1;
          else                                  r_credit[v]  <= r_credit[v] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_out_vc    <= '0;
      r_rr        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_out_flit  <= r_mem[w_pick][r_rd_ptr[w_pick]];
            r_out_vc    <= w_pick;
            r_out_valid <= 1'b1;
            r_rr        <= w_rr_next;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_accept) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    credit_cnt = '0;
    for (int v = 0; v < NUM_VCS; v++) credit_cnt[v*CW +: CW] = r_credit[v];
  end

  assign in_ready   = w_ready;
  assign out_valid  = r_out_valid;
  assign out_vc     = r_out_vc;
  assign out_flit   = r_out_flit;
  assign credit_err = r_credit_err;

`ifdef ECB_STATS_EN
  logic [15:0] r_sent [NUM_VCS];
  logic [15:0] r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VCS; v++) r_sent[v] <= '0;
      r_stall <= '0;
    end else begin
      if (r_state == S_SEND && out_accept) r_sent[r_out_vc] <= r_sent[r_out_vc] + 16'd1;
      if (r_state == S_IDLE && (|w_nonempty) && !w_found) r_stall <= r_stall + 16'd1;
    end
  end

  always_comb begin
    sent_cnt = '0;
    for (int v = 0; v < NUM_VCS; v++) sent_cnt[v*16 +: 16] = r_sent[v];
  end

  assign stall_cnt = r_stall;
`endif

endmodule
